// File: rtl/chess_pkg.sv
// Shared move-generator definitions.
// Holds move field layout, FIFO word geometry, piece codes shared with the
// square units, the collector FSM state type and a small move-pack helper.
package chess_pkg;

  // Move layout: [18:12] flags, [11:6] from, [5:0] to
  localparam int MV_W          = 19;
  localparam int FLAG_INVALID  = 18;
  localparam int FLAG_PROMOTE  = 17;
  localparam int FLAG_PAWN     = 16;
  localparam int FLAG_PAWN2    = 15;
  localparam int FLAG_ENPASS   = 14;
  localparam int FLAG_CASTLE   = 13;
  localparam int FLAG_CAPTURE  = 12;
  localparam int FROM_MSB      = 11;
  localparam int FROM_LSB      = 6;
  localparam int TO_MSB        = 5;
  localparam int TO_LSB        = 0;

  // FIFO word geometry
  localparam int MOVES_PER_WORD = 8;
  localparam int WORD_W         = MV_W * MOVES_PER_WORD;
  localparam int SLOT_W         = $clog2(MOVES_PER_WORD);

  typedef enum logic [2:0] {
    PIECE_NONE   = 3'd0,
    PIECE_PAWN   = 3'd1,
    PIECE_KNIGHT = 3'd2,
    PIECE_BISHOP = 3'd3,
    PIECE_ROOK   = 3'd4,
    PIECE_QUEEN  = 3'd5,
    PIECE_KING   = 3'd6
  } piece_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DONE = 3'd1,
    SCAN      = 3'd2,
    CAPTURE   = 3'd3,
    EMIT      = 3'd4,
    FINISH    = 3'd5
  } coll_state_e;

  function automatic logic [MV_W-1:0] mv_pack(input logic [6:0] flags,
                                              input logic [5:0] from,
                                              input logic [5:0] to);
    return {flags, from, to};
  endfunction

endpackage

// File: rtl/move_slot_picker.sv
// Combinational priority select over the eight move slots of a FIFO word.
// Ports:
//   word  in  WORD_W       packed word, slot k at [19k+18:19k]
//   mask  in  8            slot-valid mask
//   any   out 1            at least one mask bit set
//   slot  out SLOT_W       index of the highest set mask bit
//   move  out MV_W         move held in that slot (0 when mask is empty)
module move_slot_picker
  import chess_pkg::*;
(
  input  logic [WORD_W-1:0]         word,
  input  logic [MOVES_PER_WORD-1:0] mask,
  output logic                      any,
  output logic [SLOT_W-1:0]         slot,
  output logic [MV_W-1:0]           move
);

  logic [MV_W-1:0] slots [MOVES_PER_WORD];

  genvar gi;
  generate
    for (gi = 0; gi < MOVES_PER_WORD; gi++) begin : g_slot
      assign slots[gi] = word[gi*MV_W +: MV_W];
    end
  endgenerate

  // Ascending scan: a later (higher) set bit overrides, so the highest wins.
  always_comb begin
    any  = |mask;
    slot = '0;
    move = '0;
    for (int k = 0; k < MOVES_PER_WORD; k++) begin
      if (mask[k]) begin
        slot = SLOT_W'(k);
        move = slots[k];
      end
    end
  end

endmodule

// File: rtl/move_collector.sv
// Drain side of the per-square move FIFOs.
// Once every square unit is done, scans the NSRC FIFOs in index order, pops
// one word at a time, and streams its valid moves (slot 7 down to 0) out on a
// valid/ready interface. Counts emitted moves and pulses list_done at the end.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             one-cycle pulse to begin collecting
//   sq_done/sq_empty  per-square done and FIFO-empty flags
//   sq_data           concatenated FIFO read words, source i at [152i+:152]
//   sq_rden           one-hot FIFO pop (data arrives the following cycle)
//   mv_valid/ready/data  move output stream
//   mv_count          saturating count of moves emitted since start
//   busy, list_done   activity flag and completion pulse
module move_collector
  import chess_pkg::*;
#(
  parameter int NSRC = 64,
  parameter int CNTW = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NSRC-1:0]        sq_done,
  input  logic [NSRC-1:0]        sq_empty,
  input  logic [NSRC*WORD_W-1:0] sq_data,
  output logic [NSRC-1:0]        sq_rden,
  output logic                   mv_valid,
  input  logic                   mv_ready,
  output logic [MV_W-1:0]        mv_data,
  output logic [CNTW-1:0]        mv_count,
  output logic                   busy,
  output logic                   list_done
);

  // idx must reach NSRC to mark the end of the scan
  localparam int IDXW = $clog2(NSRC + 1);
  localparam int SELW = (NSRC > 1) ? $clog2(NSRC) : 1;

  coll_state_e               state, state_next;
  logic [IDXW-1:0]           idx, idx_next;
  logic [SELW-1:0]           sel;
  logic [WORD_W-1:0]         word;
  logic [MOVES_PER_WORD-1:0] mask, mask_next, cleared;
  logic [WORD_W-1:0]         src_word [NSRC];
  logic [MOVES_PER_WORD-1:0] src_mask;
  logic                      pick_any;
  logic [SLOT_W-1:0]         pick_slot;
  logic [MV_W-1:0]           pick_move;
  logic                      take;

  assign sel = idx[SELW-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      assign src_word[gi] = sq_data[gi*WORD_W +: WORD_W];
    end
    // A slot is usable when its invalid flag is clear
    for (gi = 0; gi < MOVES_PER_WORD; gi++) begin : g_mask
      assign src_mask[gi] = ~src_word[sel][gi*MV_W + FLAG_INVALID];
    end
  endgenerate

  move_slot_picker u_picker (
    .word (word),
    .mask (mask),
    .any  (pick_any),
    .slot (pick_slot),
    .move (pick_move)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      word     <= '0;
      mask     <= '0;
      mv_count <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      mask  <= mask_next;
      if (state == CAPTURE) begin
        word <= src_word[sel];
      end
      if (state == IDLE && start) begin
        mv_count <= '0;
      end else if (take && (mv_count != '1)) begin
        mv_count <= mv_count + CNTW'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    mask_next  = mask;
    cleared    = mask;
    sq_rden    = '0;
    mv_valid   = 1'b0;
    mv_data    = '0;
    busy       = 1'b0;
    list_done  = 1'b0;
    take       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          idx_next   = '0;
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        busy = 1'b1;
        if (&sq_done) state_next = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (idx == IDXW'(NSRC)) begin
          state_next = FINISH;
        end else if (sq_empty[sel]) begin
          idx_next = idx + IDXW'(1);
        end else begin
          sq_rden[sel] = 1'b1;
          state_next   = CAPTURE;
        end
      end
      CAPTURE: begin
        busy       = 1'b1;
        mask_next  = src_mask;
        state_next = EMIT;
      end
      EMIT: begin
        busy = 1'b1;
        if (!pick_any) begin
          // idx unchanged: the same FIFO is re-checked until it runs empty
          state_next = SCAN;
        end else begin
          mv_valid = 1'b1;
          mv_data  = pick_move;
          if (mv_ready) begin
            take      = 1'b1;
            cleared   = mask & ~(MOVES_PER_WORD'(1) << pick_slot);
            mask_next = cleared;
            // Leave directly on the last move so no idle EMIT cycle follows
            if (cleared == '0) state_next = SCAN;
          end
        end
      end
      FINISH: begin
        list_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
